// File: rtl/uart_tx_fifo_cfg_pkg.sv
// Shared definitions for the configurable UART transmitter: parity encodings,
// FSM state encoding and the baud divisor formula, reusable by a matching receiver.
package uart_tx_fifo_cfg_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    function automatic int calc_baud_div(input int sys_freq, input int baud_rate);
        return sys_freq / baud_rate;
    endfunction

    // Unknown parity codes fall back to "no parity bit".
    function automatic bit parity_enabled(input int parity);
        return (parity == PARITY_ODD) || (parity == PARITY_EVEN);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count; full/empty and ready all
// come straight from that count so no flag depends on the same-cycle read request.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LEVEL = DEPTH[PW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      count_q;
    logic [PW:0]      count_d;
    logic             wr_en;
    logic             rd_en;

    // A word transfers when wr_valid_i & wr_ready_o; ready stays low while full even if a read is in flight.
    assign wr_ready_o = (count_q != FULL_LEVEL);
    assign empty_o    = (count_q == '0);
    assign wr_en      = wr_valid_i & wr_ready_o;
    assign rd_en      = rd_en_i & ~empty_o;
    assign rd_data_o  = mem_q[rd_ptr_q];
    assign level_o    = count_q;

    always_comb begin
        count_d = count_q;
        if (wr_en && !rd_en) begin
            count_d = count_q + 1'b1;
        end else if (rd_en && !wr_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with configurable frame and input FIFO. The line value is
// computed from the current state and registered, so tx_bit trails the FSM by one clock.
module uart_tx_fifo_cfg
    import uart_tx_fifo_cfg_pkg::*;
#(
    parameter int SYSTEM_FREQ = 50_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clock,
    input  logic                          srst,
    output logic                          tx_bit,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_busy,
    output logic                          tx_frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output tx_state_e                     dbg_state
);
    localparam int BAUD_DIV = calc_baud_div(SYSTEM_FREQ, BAUD_RATE);
    localparam int BW       = $clog2(BAUD_DIV);
    localparam int CW       = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);
    localparam bit PAR_EN  = parity_enabled(PARITY);
    localparam bit PAR_ODD = (PARITY == PARITY_ODD);

    tx_state_e            state_q;
    logic [BW-1:0]        baud_cnt_q;
    logic [CW-1:0]        bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 parity_q;
    logic                 tx_bit_q;
    logic                 frame_done_q;
    logic                 busy_q;
    logic                 line_d;
    logic                 bit_end;
    logic                 stop_end;
    logic                 pop;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd_data;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clock),
        .rst_i      (srst),
        .wr_data_i  (tx_data),
        .wr_valid_i (tx_valid),
        .wr_ready_o (tx_ready),
        .rd_en_i    (pop),
        .rd_data_o  (fifo_rd_data),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    assign bit_end  = (baud_cnt_q == BAUD_LAST);
    assign stop_end = (state_q == ST_STOP) && bit_end && (bit_cnt_q == STOP_LAST);
    // Popping in the final stop clock lets the next start bit follow with no idle gap.
    assign pop      = !fifo_empty && ((state_q == ST_IDLE) || stop_end);

    always_comb begin
        line_d = 1'b1;
        case (state_q)
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = shift_q[0];
            ST_PARITY: line_d = parity_q;
            default:   line_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge srst) begin
        if (srst) begin
            state_q      <= ST_IDLE;
            baud_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            tx_bit_q     <= 1'b1;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            tx_bit_q     <= line_d;
            frame_done_q <= stop_end;
            busy_q       <= (state_q != ST_IDLE) || (fifo_level != '0);
            if (state_q != ST_IDLE) begin
                baud_cnt_q <= bit_end ? '0 : baud_cnt_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: ;
                ST_START: begin
                    if (bit_end) begin
                        state_q   <= ST_DATA;
                        bit_cnt_q <= '0;
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == DATA_LAST) begin
                            state_q   <= PAR_EN ? ST_PARITY : ST_STOP;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_end) begin
                        state_q   <= ST_STOP;
                        bit_cnt_q <= '0;
                    end
                end
                ST_STOP: begin
                    if (bit_end) begin
                        if (bit_cnt_q == STOP_LAST) begin
                            state_q <= ST_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (pop) begin
                state_q    <= ST_START;
                baud_cnt_q <= '0;
                shift_q    <= fifo_rd_data;
                parity_q   <= PAR_ODD ? ~^fifo_rd_data : ^fifo_rd_data;
            end
        end
    end

    assign tx_bit        = tx_bit_q;
    assign tx_frame_done = frame_done_q;
    assign tx_busy       = busy_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Bench for uart_tx_fifo_cfg: four frame formats (8N1, 8E1, 8O1, 7E2) side by side,
// directed timing scenarios on the 8N1 instance and random words on all of them.
module tb_uart_tx_fifo_cfg;
  localparam int SYS_F = 1_000_000;
  localparam int BAUD  = 100_000;
  localparam int BD    = SYS_F / BAUD;
  localparam int NCFG  = 4;

  function automatic int cfg_db(input int g);
    return (g == 3) ? 7 : 8;
  endfunction

  function automatic int cfg_par(input int g);
    case (g)
      1: return 2;
      2: return 1;
      3: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int cfg_sb(input int g);
    return (g == 3) ? 2 : 1;
  endfunction

  function automatic int frame_bits(input int g);
    return 1 + cfg_db(g) + ((cfg_par(g) != 0) ? 1 : 0) + cfg_sb(g);
  endfunction

  // Reference line value for line-bit position idx of word w in format g.
  function automatic logic exp_line(input int g, input logic [8:0] w, input int idx);
    int ones = 0;
    for (int i = 0; i < cfg_db(g); i++) if (w[i]) ones++;
    if (idx == 0) return 1'b0;
    if (idx <= cfg_db(g)) return w[idx-1];
    if (cfg_par(g) != 0 && idx == cfg_db(g) + 1)
      return (cfg_par(g) == 2) ? (ones % 2 == 1) : (ones % 2 == 0);
    return 1'b1;
  endfunction

  logic clock = 1'b0;
  logic srst  = 1'b1;
  logic [NCFG-1:0]       line_v, ready_v, busy_v, done_v;
  logic [NCFG-1:0]       valid_v;
  logic [NCFG-1:0][8:0]  data_v;
  logic [NCFG-1:0][2:0]  level_v, state_v;
  logic [8:0]            exp_q [NCFG][$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : gen_dut
    localparam int DB = cfg_db(g);

    uart_tx_fifo_cfg #(
      .SYSTEM_FREQ (SYS_F),
      .BAUD_RATE   (BAUD),
      .DATA_BITS   (DB),
      .PARITY      (cfg_par(g)),
      .STOP_BITS   (cfg_sb(g)),
      .FIFO_DEPTH  (4)
    ) u_dut (
      .clock         (clock),
      .srst          (srst),
      .tx_bit        (line_v[g]),
      .tx_data       (data_v[g][DB-1:0]),
      .tx_valid      (valid_v[g]),
      .tx_ready      (ready_v[g]),
      .tx_busy       (busy_v[g]),
      .tx_frame_done (done_v[g]),
      .fifo_level    (level_v[g]),
      .dbg_state     (state_v[g])
    );

    // Monitor: a start bit pops the scoreboard; every clock of the frame is compared.
    initial begin : mon
      logic [8:0] w;
      int nclk, line_bad, done_bad, first_bad;
      bit have_exp, aborted;
      forever begin
        @(negedge clock);
        if (srst) continue;
        if (line_v[g] == 1'b1) begin
          chk($sformatf("idle_done%0d", g), done_v[g], 0);
          continue;
        end
        have_exp = (exp_q[g].size() != 0);
        if (!have_exp) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame%0d: start bit seen, expected no frame", g);
          w = '0;
        end else begin
          w = exp_q[g].pop_front();
        end
        nclk = frame_bits(g) * BD;
        line_bad = 0; done_bad = 0; first_bad = -1; aborted = 0;
        for (int c = 0; c < nclk; c++) begin
          if (c > 0) @(negedge clock);
          if (srst) begin aborted = 1; break; end
          if (line_v[g] !== exp_line(g, w, c / BD)) begin
            line_bad++;
            if (first_bad < 0) first_bad = c;
          end
          if (done_v[g] !== (c == nclk - 1)) done_bad++;
        end
        if (!aborted && have_exp) begin
          chk($sformatf("frame%0d_w%03h_bad_clocks_first_at_%0d", g, w, first_bad), line_bad, 0);
          chk($sformatf("frame%0d_w%03h_done_bad_clocks", g, w), done_bad, 0);
        end
      end
    end
  end

  // Driver tasks (entered and left on a negedge)
  task automatic send(input int k, input logic [8:0] w);
    int guard = 0;
    data_v[k]  = w;
    valid_v[k] = 1'b1;
    while (!ready_v[k] && guard < 5000) begin
      @(negedge clock);
      guard++;
    end
    chk($sformatf("send%0d_ready_timeout", k), ready_v[k], 1);
    if (ready_v[k]) exp_q[k].push_back(w);
    @(negedge clock);
    valid_v[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n = 0;
    while ((busy_v[k] || exp_q[k].size() != 0) && n < 5000) begin
      @(negedge clock);
      n++;
    end
    chk($sformatf("drain%0d_timeout", k), (n < 5000), 1);
    @(negedge clock);
  endtask

  initial begin : stim
    int acc, base, rel, n_line, n_done;
    int acc_rel[6];
    int exp_rel[6];
    exp_rel = '{0, 1, 2, 3, 4, 102};
    valid_v = '0;
    data_v  = '0;
    srst    = 1'b1;
    repeat (3) @(negedge clock);
    for (int k = 0; k < NCFG; k++) begin
      chk($sformatf("rst_line%0d", k), line_v[k], 1);
      chk($sformatf("rst_ready%0d", k), ready_v[k], 1);
      chk($sformatf("rst_busy%0d", k), busy_v[k], 0);
      chk($sformatf("rst_done%0d", k), done_v[k], 0);
      chk($sformatf("rst_level%0d", k), level_v[k], 0);
    end
    srst = 1'b0;
    @(negedge clock);

    // 8N1 0xA5 and the two-edge start latency
    data_v[0] = 9'h0A5; valid_v[0] = 1'b1; exp_q[0].push_back(9'h0A5);
    @(negedge clock);
    valid_v[0] = 1'b0;
    chk("lat_level_N", level_v[0], 1);
    chk("lat_line_N", line_v[0], 1);
    @(negedge clock);
    chk("lat_line_N1", line_v[0], 1);
    chk("lat_busy_N1", busy_v[0], 1);
    @(negedge clock);
    chk("lat_line_N2", line_v[0], 0);
    wait_idle(0);

    // Burst of six words with valid held: fill, full-with-pop, back-to-back frames
    acc = 0; base = -1;
    data_v[0] = 9'd1; valid_v[0] = 1'b1;
    for (int guard = 0; guard < 800; guard++) begin
      rel = (base < 0) ? -1 : cyc - base;
      if (rel == 5) begin chk("burst_full_level", level_v[0], 4); chk("burst_full_ready", ready_v[0], 0); end
      if (rel == 100) begin chk("pop_pre_level", level_v[0], 4); chk("pop_pre_ready", ready_v[0], 0); end
      if (rel == 101) begin chk("pop_level", level_v[0], 3); chk("pop_ready", ready_v[0], 1); end
      if (rel == 102) chk("pop_refill_level", level_v[0], 4);
      if (rel == 601) chk("burst_busy_last", busy_v[0], 1);
      if (rel == 602) begin chk("burst_busy_fall", busy_v[0], 0); break; end
      if (valid_v[0] && ready_v[0]) begin
        if (base < 0) base = cyc + 1;
        acc_rel[acc] = cyc + 1 - base;
        exp_q[0].push_back(data_v[0]);
        acc++;
      end
      @(negedge clock);
      if (acc == 6) valid_v[0] = 1'b0;
      else data_v[0] = 9'(acc + 1);
    end
    valid_v[0] = 1'b0;
    chk("burst_accepts", acc, 6);
    for (int i = 0; i < 6; i++)
      if (i < acc) chk($sformatf("burst_accept_cycle%0d", i), acc_rel[i], exp_rel[i]);
    wait_idle(0);

    // Reset 37 clocks into a frame with a second word queued
    data_v[0] = 9'h05A; valid_v[0] = 1'b1; exp_q[0].push_back(9'h05A);
    @(negedge clock);
    data_v[0] = 9'h0C3; exp_q[0].push_back(9'h0C3);
    @(negedge clock);
    valid_v[0] = 1'b0;
    n_line = 0;
    while (line_v[0] !== 1'b0 && n_line < 20) begin @(negedge clock); n_line++; end
    chk("rst_test_start_seen", (n_line < 20), 1);
    repeat (36) @(posedge clock);
    #2;
    chk("pre_rst_line_low", line_v[0], 0);
    srst = 1'b1;
    #1;
    chk("async_rst_line", line_v[0], 1);
    chk("async_rst_level", level_v[0], 0);
    chk("async_rst_ready", ready_v[0], 1);
    chk("async_rst_busy", busy_v[0], 0);
    exp_q[0].delete();
    repeat (2) @(negedge clock);
    srst = 1'b0;
    @(negedge clock);
    send(0, 9'h05A);
    wait_idle(0);

    // Idle line for 1000 clocks
    n_line = 0; n_done = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (line_v[0] !== 1'b1) n_line++;
      if (done_v[0] !== 1'b0) n_done++;
    end
    chk("idle_line_low_clocks", n_line, 0);
    chk("idle_done_pulses", n_done, 0);

    // Parity formats with known words, then random words on every format
    send(1, 9'h0A5);
    send(2, 9'h0A5);
    send(3, 9'h041);
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < NCFG; k++) begin
        send(k, 9'($urandom_range(0, (1 << cfg_db(k)) - 1)));
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 40)) @(negedge clock);
      end
    end
    for (int k = 0; k < NCFG; k++) wait_idle(k);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #500_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
